// File: rtl/laplace_sum_sequencer_if.sv
// Operand stream, shared-adder and result handshake bundle for laplace_sum_sequencer.
// The sequencer binds the master modport; the window buffer, adder and combine stage face the slave modport.
interface laplace_sum_sequencer_if #(
    parameter int HW = 2
);
    logic            op_valid;
    logic            op_ready;
    logic [7:0]      op_data;
    logic [7:0]      add_a;
    logic [7:0]      add_b;
    logic            add_cin;
    logic [7:0]      add_s;
    logic            add_cout;
    logic            res_valid;
    logic            res_ready;
    logic [8+HW-1:0] res_data;
    logic            busy;

    modport master (
        input  op_valid, op_data, add_s, add_cout, res_ready,
        output op_ready, add_a, add_b, add_cin, res_valid, res_data, busy
    );

    modport slave (
        output op_valid, op_data, add_s, add_cout, res_ready,
        input  op_ready, add_a, add_b, add_cin, res_valid, res_data, busy
    );
endinterface

// File: rtl/laplace_sum_sequencer.sv
// Sequences an external 8-bit adder to sum NUM_TERMS operands, counting carry-outs into a high field.
// Optional LAPLACE_SEQ_SATURATE_EN clamps the presented result to 255 when any carry was counted.
module laplace_sum_sequencer #(
    parameter int NUM_TERMS = 4,
    parameter int HW        = $clog2(NUM_TERMS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    laplace_sum_sequencer_if.master  bus
);
    localparam int         RW   = 8 + HW;
    localparam logic [4:0] LAST = 5'(NUM_TERMS);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t          state;
    logic [4:0]      cnt;
    logic [7:0]      acc_lo;
    logic [HW-1:0]   acc_hi;
    logic            accept;

    assign accept      = bus.op_valid && bus.op_ready;
    assign bus.add_a   = acc_lo;
    assign bus.add_b   = bus.op_data;
    assign bus.add_cin = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            acc_lo        <= '0;
            acc_hi        <= '0;
            bus.op_ready  <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else if (flush || (state == DONE && bus.res_ready)) begin
            // flush and the result handshake share the same clear-to-idle path
            state         <= IDLE;
            cnt           <= '0;
            acc_lo        <= '0;
            acc_hi        <= '0;
            bus.op_ready  <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else if (accept) begin
            acc_lo <= bus.add_s;
            acc_hi <= acc_hi + HW'(bus.add_cout);
            cnt    <= cnt + 5'd1;
            if (state == IDLE) begin
                state    <= ACCUM;
                bus.busy <= 1'b1;
            end else if (cnt + 5'd1 == LAST) begin
                state         <= DONE;
                bus.op_ready  <= 1'b0;
                bus.res_valid <= 1'b1;
            end
        end
    end

`ifdef LAPLACE_SEQ_SATURATE_EN
    assign bus.res_data = (acc_hi != '0) ? RW'(8'hFF) : RW'(acc_lo);
`else
    assign bus.res_data = {acc_hi, acc_lo};
`endif
endmodule

// File: tb/tb_laplace_sum_sequencer.sv
// Scoreboard bench for laplace_sum_sequencer with an exact adder model and a forceable carry path.
// Expected sums come from plain arithmetic over the accepted operand list.
module tb_laplace_sum_sequencer;
    localparam int NUM_TERMS = 4;
    localparam int HW        = $clog2(NUM_TERMS);
    localparam int RW        = 8 + HW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    laplace_sum_sequencer_if #(.HW(HW)) bus ();

    laplace_sum_sequencer #(.NUM_TERMS(NUM_TERMS), .HW(HW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    logic       op_valid = 1'b0;
    logic [7:0] op_data  = 8'h00;
    logic       rr_random = 1'b0;
    logic       rr_level  = 1'b1;
    logic       rr_bit    = 1'b1;
    logic       force_add = 1'b0;
    logic [8:0] exact;

    assign bus.op_valid  = op_valid;
    assign bus.op_data   = op_data;
    assign bus.res_ready = rr_random ? rr_bit : rr_level;
    assign exact         = {1'b0, bus.add_a} + {1'b0, bus.add_b};
    assign bus.add_s     = force_add ? 8'h00 : exact[7:0];
    assign bus.add_cout  = force_add ? 1'b1  : exact[8];

    initial forever begin
        @(posedge clk);
        #1 rr_bit = 1'($urandom_range(0, 1));
    end

    int unsigned     tests = 0;
    int unsigned     fails = 0;
    logic [RW-1:0]   exp_q[$];
    int unsigned     model_ops[$];
    bit              model_forced = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [RW-1:0] fmt(int unsigned hi, int unsigned lo);
        int unsigned h = hi % (1 << HW);
`ifdef LAPLACE_SEQ_SATURATE_EN
        return (h != 0) ? RW'(255) : RW'(lo);
`else
        return RW'(h * 256 + lo);
`endif
    endfunction

    function automatic void note_accept(int unsigned d);
        int unsigned sum = 0;
        model_ops.push_back(d);
        if (model_ops.size() == NUM_TERMS) begin
            if (model_forced)
                exp_q.push_back(fmt(NUM_TERMS - 1, 0));
            else begin
                foreach (model_ops[i]) sum += model_ops[i];
                exp_q.push_back(fmt(sum / 256, sum % 256));
            end
            model_ops.delete();
        end
    endfunction

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_op(input logic [7:0] d);
        int unsigned n = 0;
        op_valid = 1'b1;
        op_data  = d;
        @(negedge clk);
        while (!bus.op_ready && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (!bus.op_ready) begin
            tests++;
            fails++;
            $display("FAIL op_accept_timeout: op_ready stayed %0b, required 1", bus.op_ready);
        end else
            note_accept(d);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush    = 1'b1;
        op_valid = 1'b1;
        op_data  = 8'd99;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        op_valid = 1'b0;
        model_ops.delete();
        @(negedge clk);
        check("flush_busy", 32'(bus.busy), 0);
        check("flush_op_ready", 32'(bus.op_ready), 1);
        @(posedge clk);
        #1;
    endtask

    // monitor: every DONE cycle is checked against the head of the scoreboard
    initial forever begin
        @(negedge clk);
        if (bus.res_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: res_data %0h presented, no result expected", bus.res_data);
            end else begin
                check("res_data", 32'(bus.res_data), 32'(exp_q[0]));
                check("done_op_ready", 32'(bus.op_ready), 0);
                check("done_busy", 32'(bus.busy), 1);
                if (bus.res_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int unsigned n;
        int unsigned k;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_op_ready", 32'(bus.op_ready), 1);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_data", 32'(bus.res_data), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("add_cin", 32'(bus.add_cin), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // back-to-back 10,20,30,40 with latency and single-bubble checks
        send_op(8'd10);
        send_op(8'd20);
        send_op(8'd30);
        send_op(8'd40);
        @(negedge clk);
        check("latency_res_valid", 32'(bus.res_valid), 1);
        check("latency_op_ready", 32'(bus.op_ready), 0);
        @(negedge clk);
        check("bubble_res_valid", 32'(bus.res_valid), 0);
        check("bubble_op_ready", 32'(bus.op_ready), 1);
        @(posedge clk);
        #1;

        repeat (NUM_TERMS) send_op(8'hFF);
        idle(2);

        // result backpressure for five cycles with an operand waiting
        rr_level = 1'b0;
        repeat (NUM_TERMS) send_op(8'($urandom_range(0, 255)));
        op_valid = 1'b1;
        op_data  = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res_valid", 32'(bus.res_valid), 1);
            check("bp_op_ready", 32'(bus.op_ready), 0);
        end
        @(posedge clk);
        #1 rr_level = 1'b1;
        send_op(8'd7);
        repeat (NUM_TERMS - 1) send_op(8'($urandom_range(0, 255)));
        idle(2);

        // flush after two operands, then a clean sum of ones
        send_op(8'd50);
        send_op(8'd60);
        do_flush();
        repeat (NUM_TERMS) send_op(8'd1);
        idle(2);

        // forced adder: carry on every accept after the first
        send_op(8'h80);
        force_add    = 1'b1;
        model_forced = 1'b1;
        repeat (NUM_TERMS - 1) send_op(8'h80);
        force_add    = 1'b0;
        model_forced = 1'b0;
        idle(2);

        // asynchronous reset between edges mid-accumulation
        send_op(8'($urandom_range(0, 255)));
        send_op(8'($urandom_range(0, 255)));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_op_ready", 32'(bus.op_ready), 1);
        check("arst_res_valid", 32'(bus.res_valid), 0);
        check("arst_res_data", 32'(bus.res_data), 0);
        check("arst_busy", 32'(bus.busy), 0);
        model_ops.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (NUM_TERMS) send_op(8'($urandom_range(0, 255)));
        idle(2);

        // randomized groups with gaps, random res_ready and occasional flush
        rr_random = 1'b1;
        for (int g = 0; g < 30; g++) begin
            k = ($urandom_range(0, 7) == 0) ? $urandom_range(1, NUM_TERMS - 1) : NUM_TERMS;
            for (int unsigned i = 0; i < k; i++) begin
                idle($urandom_range(0, 2));
                send_op(8'($urandom_range(0, 255)));
            end
            if (k < NUM_TERMS) do_flush();
        end
        rr_random = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("queue_drained", 32'(exp_q.size()), 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
